memory_arbiter: RTL

- Shares one single-ported `simple_memory` instance between two requesters: instruction fetch (port I, read-only) and load/store (port D, read/write).
- Arbitrates round-robin, sequences one memory access per grant, and returns a one-cycle ack with read data.
- Rejects accesses outside the memory's byte range.
- Sits between the CPU core and `simple_memory`. All memory-side outputs are registered on posedge, so the memory's negedge sampling sees stable values.

---
 rtl/memory_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Shares one single-ported simple_memory between instruction fetch (I) and load/store (D).
// Round-robin by default; define MEM_ARB_DATA_PRIORITY_EN to give D fixed priority.
module memory_arbiter #(
    parameter logic [31:0] pWords = 32'd44
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwIReq,
    input  logic [31:0] iwIAddr,
    output logic        orIAck,
    output logic [31:0] orIRData,
    output logic        orIErr,
    input  logic        iwDReq,
    input  logic [31:0] iwDAddr,
    input  logic [31:0] iwDWData,
    input  logic [3:0]  iwDWstrb,
    output logic        orDAck,
    output logic [31:0] orDRData,
    output logic        orDErr,
    output logic [31:0] orMemReadAddr,
    output logic [31:0] orMemWriteAddr,
    output logic [31:0] orMemWriteData,
    output logic [3:0]  orMemWstrb,
    input  logic [31:0] iwMemReadData
);

    // Highest legal word address; 33 bits so addresses near 2^32 cannot wrap into range.
    localparam logic [32:0] cLastWordAddr = ({1'b0, pWords} << 2) - 33'd4;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_reg, state_next;
    logic        gnt_d_reg, gnt_d_next;
    logic        err_reg, err_next;
    logic        store_reg, store_next;
    logic        i_ack_reg, i_ack_next;
    logic        i_err_reg, i_err_next;
    logic [31:0] i_rdata_reg, i_rdata_next;
    logic        d_ack_reg, d_ack_next;
    logic        d_err_reg, d_err_next;
    logic [31:0] d_rdata_reg, d_rdata_next;
    logic [31:0] mem_raddr_reg, mem_raddr_next;
    logic [31:0] mem_waddr_reg, mem_waddr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [3:0]  mem_wstrb_reg, mem_wstrb_next;

    logic        pick_d;
    logic [31:0] sel_addr;
    logic        sel_err;

`ifdef MEM_ARB_DATA_PRIORITY_EN
    assign pick_d = iwDReq;
`else
    logic last_grant_reg, last_grant_next;  // 1 = D was granted last

    // On a tie D wins unless it was the last one served.
    assign pick_d = iwDReq && (!iwIReq || !last_grant_reg);

    always_comb begin
        last_grant_next = last_grant_reg;
        if (state_reg == IDLE && (iwIReq || iwDReq)) begin
            last_grant_next = pick_d;
        end
    end

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            last_grant_reg <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`endif

    assign sel_addr = pick_d ? iwDAddr : iwIAddr;
    assign sel_err  = {1'b0, sel_addr} > cLastWordAddr;

    always_comb begin
        state_next     = state_reg;
        gnt_d_next     = gnt_d_reg;
        err_next       = err_reg;
        store_next     = store_reg;
        i_ack_next     = 1'b0;
        i_err_next     = 1'b0;
        i_rdata_next   = i_rdata_reg;
        d_ack_next     = 1'b0;
        d_err_next     = 1'b0;
        d_rdata_next   = d_rdata_reg;
        mem_raddr_next = mem_raddr_reg;
        mem_waddr_next = mem_waddr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = mem_wstrb_reg;
        unique case (state_reg)
            IDLE: begin
                if (iwIReq || iwDReq) begin
                    gnt_d_next     = pick_d;
                    err_next       = sel_err;
                    store_next     = pick_d && (iwDWstrb != 4'd0);
                    mem_raddr_next = sel_addr;
                    mem_waddr_next = sel_addr;
                    mem_wdata_next = pick_d ? iwDWData : 32'd0;
                    mem_wstrb_next = (pick_d && !sel_err) ? iwDWstrb : 4'd0;
                    state_next     = ACCESS;
                end
            end
            ACCESS: begin
                // The memory has completed the access on the negedge inside this cycle.
                mem_wstrb_next = 4'd0;
                if (gnt_d_reg) begin
                    d_ack_next = 1'b1;
                    d_err_next = err_reg;
                    if (!store_reg) begin
                        d_rdata_next = err_reg ? 32'd0 : iwMemReadData;
                    end
                end else begin
                    i_ack_next   = 1'b1;
                    i_err_next   = err_reg;
                    i_rdata_next = err_reg ? 32'd0 : iwMemReadData;
                end
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state_reg     <= IDLE;
            gnt_d_reg     <= 1'b0;
            err_reg       <= 1'b0;
            store_reg     <= 1'b0;
            i_ack_reg     <= 1'b0;
            i_err_reg     <= 1'b0;
            i_rdata_reg   <= 32'd0;
            d_ack_reg     <= 1'b0;
            d_err_reg     <= 1'b0;
            d_rdata_reg   <= 32'd0;
            mem_raddr_reg <= 32'd0;
            mem_waddr_reg <= 32'd0;
            mem_wdata_reg <= 32'd0;
            mem_wstrb_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            gnt_d_reg     <= gnt_d_next;
            err_reg       <= err_next;
            store_reg     <= store_next;
            i_ack_reg     <= i_ack_next;
            i_err_reg     <= i_err_next;
            i_rdata_reg   <= i_rdata_next;
            d_ack_reg     <= d_ack_next;
            d_err_reg     <= d_err_next;
            d_rdata_reg   <= d_rdata_next;
            mem_raddr_reg <= mem_raddr_next;
            mem_waddr_reg <= mem_waddr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
        end
    end

    assign orIAck         = i_ack_reg;
    assign orIErr         = i_err_reg;
    assign orIRData       = i_rdata_reg;
    assign orDAck         = d_ack_reg;
    assign orDErr         = d_err_reg;
    assign orDRData       = d_rdata_reg;
    assign orMemReadAddr  = mem_raddr_reg;
    assign orMemWriteAddr = mem_waddr_reg;
    assign orMemWriteData = mem_wdata_reg;
    assign orMemWstrb     = mem_wstrb_reg;

endmodule
